hyperram_axi_arbiter: RTL
=========================

// Module: hyperram_axi_arbiter
// PURPOSE
//  Shares one single-outstanding AXI4-Lite port into the HyperRAM controller between two masters.
//  M0: hyperram AXI read/write test engine. M1: USB/register-bus bridge for direct HyperRAM peeks/pokes.
//  Round-robin grant, held for a whole transaction: address + data + response.
//  Exactly one transaction is outstanding downstream at any time.
// PARAMETERS
//  ADDR_W  32  address width, all AW/AR channels
//  DATA_W  32  data width, all W/R channels
//  CNT_W   16  width of per-master completed-transaction counters
// PORTS
//  clk               in   1       system clock, HyperRAM controller domain
//  reset_n           in   1       asynchronous active-low reset
//  mN_awaddr/awvalid/awready    in/in/out    ADDR_W/1/1   master N write address, N=0,1
//  mN_wdata/wvalid/wready       in/in/out    DATA_W/1/1   master N write data
//  mN_bresp/bvalid/bready       out/out/in   2/1/1        master N write response
//  mN_araddr/arvalid/arready    in/in/out    ADDR_W/1/1   master N read address
//  mN_rdata/rresp/rvalid/rready out/out/out/in DATA_W/2/1/1 master N read data
//  s_aw*/s_w*/s_b*/s_ar*/s_r*   mirrored     same widths  downstream port to HyperRAM controller
//  busy              out  1       transaction in progress (state != IDLE)
//  grant             out  2       one-hot owner: bit0=M0, bit1=M1; 0 when idle
//  m0_count/m1_count out  CNT_W   completed transactions per master, saturating
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, last=M1 (M0 wins the first tie), counts=0.
//  Reset: all s_*valid=0, all m*_ready=0, m*_bvalid/rvalid=0. Applies immediately on reset_n fall.
//  Request: reqN = mN_awvalid | mN_arvalid. Nothing is forwarded while IDLE.
//  IDLE, one req: grant that master. Both req: grant the master != last.
//  IDLE: within the granted master, write wins if awvalid and arvalid are both high.
//  Next state: WR_ADDR (write) or RD_ADDR (read). Grant is registered.
//  Latency: req high in IDLE at cycle N -> s_awvalid or s_arvalid high at N+1.
//  WR_ADDR: s_aw*/s_w* combinationally follow the granted master.
//  WR_ADDR: aw_done set on s_awvalid&s_awready; w_done set on s_wvalid&s_wready.
//  WR_ADDR: after aw_done, s_awvalid and mN_awready are forced 0; after w_done, s_wvalid and mN_wready forced 0.
//  WR_ADDR: both done (same cycle or different cycles) -> WR_RESP.
//  WR_RESP: s_b* routed to the granted master; s_bready = mN_bready.
//  WR_RESP: s_bvalid & mN_bready -> IDLE; last <= granted master; count++.
//  RD_ADDR: s_ar* follows the granted master; s_arvalid & s_arready -> RD_RESP.
//  RD_RESP: s_r* routed to the granted master; s_rvalid & mN_rready -> IDLE; last <= granted master; count++.
//  Non-granted master: all its ready/valid outputs are 0; its bresp/rresp/rdata are 0.
//  Downstream resp (SLVERR etc.) passes through unchanged; the arbiter does not interpret it.
//  Each transaction returns through IDLE: a 1-cycle bubble, which guarantees a fairness check.
//  Requests that drop before grant are ignored. The AXI rule is that valid must not drop.
//  A master's request arriving mid-transaction waits; the other master cannot starve it (round-robin).
//  Counters saturate at 2^CNT_W-1 and do not wrap.
//  Reset mid-transaction: transaction is abandoned. The HyperRAM controller shares reset_n and discards it too.
//  Unexpected s_bvalid/s_rvalid in the wrong state: ignored, and s_bready/s_rready held 0.
// STRUCTURE
//  Shared pkg hyperram_arb_pkg: state encoding (IDLE/WR_ADDR/WR_RESP/RD_ADDR/RD_RESP, 3 bits).
//  Shared pkg hyperram_arb_pkg: master index localparams, AXI resp codes (OKAY=2'b00, SLVERR=2'b10).
//  One sub-module, rr_pick2: 2-way round-robin picker (req[1:0], last -> onehot grant), purely combinational.
//  Muxes are combinational, with no added pipeline stage; registers are state, grant, last, aw_done, w_done, counts.
// TESTING
//  Only M0 writes 0xDEADBEEF @0x100, slave awready/wready 1 cycle apart -> one s_aw + one s_w beat;
//  m0_bvalid on s_bvalid; m0_count=1.
//  M0 and M1 both assert arvalid in the same cycle after reset -> M0 granted first, M1 second;
//  M1 rdata not visible to M0; counts 1/1.
//  M0 requests continuously, M1 requests once -> M1 granted within one transaction; grants alternate M0,M1,M0.
//  M0 awvalid and arvalid together -> write completes first; read granted only after the next IDLE arbitration.
//  Slave holds bvalid while m0_bready=0 for 5 cycles -> state stays WR_RESP; M1 never granted meanwhile.
//  reset_n low during RD_RESP, then high -> all valids 0 at once; grant=0; counts=0; next request granted normally.

Source files
------------

// File: rtl/hyperram_arb_pkg.sv
// rtl/hyperram_arb_pkg.sv - shared types and constants for the HyperRAM AXI4-Lite arbiter
package hyperram_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_ADDR = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_ADDR = 3'd3,
      ST_RD_RESP = 3'd4
   } arb_state_e;

   localparam int unsigned M0_IDX = 0;
   localparam int unsigned M1_IDX = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - 2-way round-robin picker; last_i=1 means M1 was served last
module rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/hyperram_axi_arbiter.sv
// rtl/hyperram_axi_arbiter.sv - two-master, single-outstanding AXI4-Lite arbiter in front of the HyperRAM controller
module hyperram_axi_arbiter
   import hyperram_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_awaddr,
   input  logic              m0_awvalid,
   output logic              m0_awready,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m0_wvalid,
   output logic              m0_wready,
   output logic [1:0]        m0_bresp,
   output logic              m0_bvalid,
   input  logic              m0_bready,
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   input  logic [ADDR_W-1:0] m1_awaddr,
   input  logic              m1_awvalid,
   output logic              m1_awready,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m1_wvalid,
   output logic              m1_wready,
   output logic [1:0]        m1_bresp,
   output logic              m1_bvalid,
   input  logic              m1_bready,
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   output logic [ADDR_W-1:0] s_awaddr,
   output logic              s_awvalid,
   input  logic              s_awready,
   output logic [DATA_W-1:0] s_wdata,
   output logic              s_wvalid,
   input  logic              s_wready,
   input  logic [1:0]        s_bresp,
   input  logic              s_bvalid,
   output logic              s_bready,
   output logic [ADDR_W-1:0] s_araddr,
   output logic              s_arvalid,
   input  logic              s_arready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rvalid,
   output logic              s_rready,
   output logic              busy,
   output logic [1:0]        grant,
   output logic [CNT_W-1:0]  m0_count,
   output logic [CNT_W-1:0]  m1_count
);

   arb_state_e       state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic             last_q, last_d;
   logic             aw_done_q, aw_done_d;
   logic             w_done_q, w_done_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   logic [1:0] req;
   logic [1:0] pick;
   logic       sel;
   logic       sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
   logic       fwd_awready, fwd_wready, fwd_bvalid, fwd_arready, fwd_rvalid;
   logic       done;
   logic       b_route, r_route;

   assign req = {m1_awvalid | m1_arvalid, m0_awvalid | m0_arvalid};

   rr_pick2 u_pick (
      .req_i  (req),
      .last_i (last_q),
      .gnt_o  (pick)
   );

   // sel is only meaningful while grant_q is non-zero; every use is state-qualified
   assign sel         = grant_q[M1_IDX];
   assign sel_awvalid = sel ? m1_awvalid : m0_awvalid;
   assign sel_wvalid  = sel ? m1_wvalid  : m0_wvalid;
   assign sel_bready  = sel ? m1_bready  : m0_bready;
   assign sel_arvalid = sel ? m1_arvalid : m0_arvalid;
   assign sel_rready  = sel ? m1_rready  : m0_rready;

   assign s_awaddr = sel ? m1_awaddr : m0_awaddr;
   assign s_wdata  = sel ? m1_wdata  : m0_wdata;
   assign s_araddr = sel ? m1_araddr : m0_araddr;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      cnt0_d      = cnt0_q;
      cnt1_d      = cnt1_q;
      s_awvalid   = 1'b0;
      s_wvalid    = 1'b0;
      s_bready    = 1'b0;
      s_arvalid   = 1'b0;
      s_rready    = 1'b0;
      fwd_awready = 1'b0;
      fwd_wready  = 1'b0;
      fwd_bvalid  = 1'b0;
      fwd_arready = 1'b0;
      fwd_rvalid  = 1'b0;
      done        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (pick != 2'b00) begin
               grant_d = pick;
               if (pick[M1_IDX] ? m1_awvalid : m0_awvalid) state_d = ST_WR_ADDR;
               else                                        state_d = ST_RD_ADDR;
            end
         end
         ST_WR_ADDR: begin
            // AW and W may complete in either order; each is masked once accepted
            s_awvalid   = sel_awvalid & ~aw_done_q;
            s_wvalid    = sel_wvalid & ~w_done_q;
            fwd_awready = s_awready & ~aw_done_q;
            fwd_wready  = s_wready & ~w_done_q;
            aw_done_d   = aw_done_q | (s_awvalid & s_awready);
            w_done_d    = w_done_q | (s_wvalid & s_wready);
            if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            s_bready   = sel_bready;
            fwd_bvalid = s_bvalid;
            done       = s_bvalid & sel_bready;
         end
         ST_RD_ADDR: begin
            s_arvalid   = sel_arvalid;
            fwd_arready = s_arready;
            if (s_arvalid && s_arready) state_d = ST_RD_RESP;
         end
         ST_RD_RESP: begin
            s_rready   = sel_rready;
            fwd_rvalid = s_rvalid;
            done       = s_rvalid & sel_rready;
         end
         default: state_d = ST_IDLE;
      endcase

      if (done) begin
         state_d = ST_IDLE;
         grant_d = 2'b00;
         last_d  = sel;
         if (sel) begin
            if (cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + CNT_W'(1);
         end else begin
            if (cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= 2'b00;
         last_q    <= 1'b1;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         cnt0_q    <= '0;
         cnt1_q    <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         cnt0_q    <= cnt0_d;
         cnt1_q    <= cnt1_d;
      end
   end

   assign b_route = (state_q == ST_WR_RESP);
   assign r_route = (state_q == ST_RD_RESP);

   assign m0_awready = grant_q[M0_IDX] & fwd_awready;
   assign m0_wready  = grant_q[M0_IDX] & fwd_wready;
   assign m0_bvalid  = grant_q[M0_IDX] & fwd_bvalid;
   assign m0_arready = grant_q[M0_IDX] & fwd_arready;
   assign m0_rvalid  = grant_q[M0_IDX] & fwd_rvalid;
   assign m0_bresp   = (grant_q[M0_IDX] && b_route) ? s_bresp : RESP_OKAY;
   assign m0_rresp   = (grant_q[M0_IDX] && r_route) ? s_rresp : RESP_OKAY;
   assign m0_rdata   = (grant_q[M0_IDX] && r_route) ? s_rdata : '0;

   assign m1_awready = grant_q[M1_IDX] & fwd_awready;
   assign m1_wready  = grant_q[M1_IDX] & fwd_wready;
   assign m1_bvalid  = grant_q[M1_IDX] & fwd_bvalid;
   assign m1_arready = grant_q[M1_IDX] & fwd_arready;
   assign m1_rvalid  = grant_q[M1_IDX] & fwd_rvalid;
   assign m1_bresp   = (grant_q[M1_IDX] && b_route) ? s_bresp : RESP_OKAY;
   assign m1_rresp   = (grant_q[M1_IDX] && r_route) ? s_rresp : RESP_OKAY;
   assign m1_rdata   = (grant_q[M1_IDX] && r_route) ? s_rdata : '0;

   assign busy     = (state_q != ST_IDLE);
   assign grant    = grant_q;
   assign m0_count = cnt0_q;
   assign m1_count = cnt1_q;

endmodule
